can_bit_timing: RTL and testbench

- CAN Bit Timing Logic; consumes the time-quantum tick from the baud rate prescaler.
- Segments each nominal bit into SYNC, TSEG1 (PROP+PHASE1) and TSEG2 (PHASE2).
- Produces the receive sample point and the transmit bit boundary.
- Performs hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges of the bus.
- Sits between the prescaler and the bit stream processor (TX/RX shift logic).

---
 rtl/can_pkg.sv | 17 +
 rtl/can_bit_timing_if.sv | 28 ++
 rtl/can_edge_detect.sv | 24 ++
 rtl/can_bit_timing.sv | 153 +++++++++++++++
 tb/tb_can_bit_timing.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// Shared types and defaults for the CAN bit timing logic.
package can_pkg;

  typedef enum logic [1:0] {
    SYNC,
    TSEG1,
    TSEG2
  } state_t;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  localparam int unsigned SEG_W_DEF = 3;
  localparam int unsigned SJW_W_DEF = 2;
  localparam int unsigned CNT_W_DEF = 5;

endpackage

// File: rtl/can_bit_timing_if.sv
// Controller-side bundle: segment configuration, TX bit, and timing pulses.
interface can_bit_timing_if
  import can_pkg::*;
#(
  parameter int unsigned SEG_W = SEG_W_DEF,
  parameter int unsigned SJW_W = SJW_W_DEF
);
  logic [SEG_W-1:0] prop_seg;
  logic [SEG_W-1:0] phase_seg1;
  logic [SEG_W-1:0] phase_seg2;
  logic [SJW_W-1:0] sjw;
  logic             hard_sync_en;
  logic             tx_bit;
  logic             sample_point;
  logic             sampled_bit;
  logic             tx_point;
  logic             hard_synced;

  modport master (
    output prop_seg, phase_seg1, phase_seg2, sjw, hard_sync_en, tx_bit,
    input  sample_point, sampled_bit, tx_point, hard_synced
  );

  modport slave (
    input  prop_seg, phase_seg1, phase_seg2, sjw, hard_sync_en, tx_bit,
    output sample_point, sampled_bit, tx_point, hard_synced
  );
endinterface

// File: rtl/can_edge_detect.sv
// Recessive-to-dominant edge detector evaluated once per time quantum.
module can_edge_detect
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tq_tick,
  input  logic rx,
  output logic fall
);
  logic rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev <= RECESSIVE;
    end else if (tq_tick) begin
      rx_prev <= rx;
    end
  end

  always_comb begin
    fall = tq_tick && (rx_prev == RECESSIVE) && (rx == DOMINANT);
  end
endmodule

// File: rtl/can_bit_timing.sv
// CAN bit timing: segments each bit into SYNC/TSEG1/TSEG2, samples rx, drives can_tx.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int unsigned SEG_W = SEG_W_DEF,
  parameter int unsigned SJW_W = SJW_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tq_tick,
  input  logic          rx,
  output logic          can_tx,
  can_bit_timing_if.slave bt
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, l1, l1_n, l2, l2_n, sj, sj_n;
  logic [CNT_W-1:0] ext, ext_n, shr, shr_n, remain;
  logic             rdone, rdone_n, can_tx_n, sbit, sbit_n;
  logic             fall, resync, sp_pulse, tp_pulse, hs_pulse;
  logic [SEG_W-1:0] prop, ps1, ps2;
  logic [SJW_W-1:0] sjw_cfg;

  assign prop    = bt.prop_seg;
  assign ps1     = bt.phase_seg1;
  assign ps2     = bt.phase_seg2;
  assign sjw_cfg = bt.sjw;

  can_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .tq_tick (tq_tick),
    .rx      (rx),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SYNC;
      cnt    <= '0;
      l1     <= '0;
      l2     <= '0;
      sj     <= '0;
      ext    <= '0;
      shr    <= '0;
      rdone  <= 1'b0;
      can_tx <= RECESSIVE;
      sbit   <= RECESSIVE;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      l1     <= l1_n;
      l2     <= l2_n;
      sj     <= sj_n;
      ext    <= ext_n;
      shr    <= shr_n;
      rdone  <= rdone_n;
      can_tx <= can_tx_n;
      sbit   <= sbit_n;
    end
  end

  assign remain = l2 - ONE - cnt;
  assign resync = fall && !bt.hard_sync_en && !rdone && (sbit == RECESSIVE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    l1_n     = l1;
    l2_n     = l2;
    sj_n     = sj;
    ext_n    = ext;
    shr_n    = shr;
    rdone_n  = rdone;
    can_tx_n = can_tx;
    sbit_n   = sbit;
    sp_pulse = 1'b0;
    tp_pulse = 1'b0;
    hs_pulse = 1'b0;

    if (tq_tick) begin
      // Every tq that acts as SYNC (real SYNC, hard sync, early bit end) latches config.
      if ((state == SYNC) || (fall && bt.hard_sync_en) ||
          (state == TSEG2 && resync && remain < sj)) begin
        l1_n = CNT_W'(prop) + CNT_W'(ps1) + CNT_W'(2);
        l2_n = CNT_W'(ps2) + ONE;
        sj_n = CNT_W'(sjw_cfg) + ONE;
      end

      if (fall && bt.hard_sync_en) begin
        state_n  = TSEG1;
        cnt_n    = '0;
        ext_n    = '0;
        shr_n    = '0;
        rdone_n  = 1'b0;
        hs_pulse = 1'b1;
      end else begin
        unique case (state)
          SYNC: begin
            state_n = TSEG1;
            cnt_n   = '0;
            ext_n   = '0;
            shr_n   = '0;
          end
          TSEG1: begin
            if (cnt == l1 + ext - ONE) begin
              sp_pulse = 1'b1;
              sbit_n   = rx;
              rdone_n  = 1'b0;
              state_n  = TSEG2;
              cnt_n    = '0;
            end else begin
              cnt_n = cnt + ONE;
            end
            if (resync) begin
              ext_n   = (cnt + ONE < sj) ? cnt + ONE : sj;
              rdone_n = 1'b1;
            end
          end
          TSEG2: begin
            if (resync) rdone_n = 1'b1;
            if (resync && remain < sj) begin
              state_n  = TSEG1;
              cnt_n    = '0;
              ext_n    = '0;
              shr_n    = '0;
              tp_pulse = 1'b1;
              can_tx_n = bt.tx_bit;
            end else begin
              if (resync) shr_n = sj;
              // >= so a shortening that lands at or before the current count ends the bit.
              if (cnt + shr >= l2 - ONE) begin
                state_n  = SYNC;
                tp_pulse = 1'b1;
                can_tx_n = bt.tx_bit;
              end else begin
                cnt_n = cnt + ONE;
              end
            end
          end
          default: state_n = SYNC;
        endcase
      end
    end
  end

  assign bt.sample_point = sp_pulse;
  assign bt.tx_point     = tp_pulse;
  assign bt.hard_synced  = hs_pulse;
  assign bt.sampled_bit  = sbit;
endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: prop=2, ps1=2, ps2=2 (10 tq bit), tq_tick every 4 clk.
module tb_can_bit_timing;
  logic clk = 1'b0;
  logic rst_n;
  logic tq_tick;
  logic rx;
  logic can_tx;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] pat = 4'b1101;

  can_bit_timing_if #(.SEG_W(3), .SJW_W(2)) bt_if ();

  can_bit_timing #(.SEG_W(3), .SJW_W(2), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tq_tick (tq_tick),
    .rx      (rx),
    .can_tx  (can_tx),
    .bt      (bt_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag, input int t, input logic esp, input logic etp,
                      input logic ehs);
    @(posedge clk);
    #1 tq_tick = 1'b1;
    @(negedge clk);
    check($sformatf("%s_t%0d_sp", tag, t), bt_if.sample_point, esp);
    check($sformatf("%s_t%0d_tp", tag, t), bt_if.tx_point, etp);
    check($sformatf("%s_t%0d_hs", tag, t), bt_if.hard_synced, ehs);
    @(posedge clk);
    #1 tq_tick = 1'b0;
    @(negedge clk);
    check($sformatf("%s_t%0d_idle", tag, t),
          bt_if.sample_point | bt_if.tx_point | bt_if.hard_synced, 1'b0);
    repeat (2) @(posedge clk);
  endtask

  task automatic ticks(input string tag, input int from, input int to, input int sp_at,
                       input int tp_at);
    for (int t = from; t <= to; t++) tick(tag, t, t == sp_at, t == tp_at, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    tq_tick = 1'b0;
    rx = 1'b1;
    bt_if.tx_bit = 1'b1;
    bt_if.prop_seg = 3'd2;
    bt_if.phase_seg1 = 3'd2;
    bt_if.phase_seg2 = 3'd2;
    bt_if.sjw = 2'd0;
    bt_if.hard_sync_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_can_tx", can_tx, 1'b1);
    check("rst_sampled", bt_if.sampled_bit, 1'b1);
    check("rst_pulses", bt_if.sample_point | bt_if.tx_point | bt_if.hard_synced, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // No edges: sample at tick 7, tx_point at tick 10, can_tx follows 1,0,1,1
    for (int b = 0; b < 4; b++) begin
      bt_if.tx_bit = pat[b];
      ticks("s1", 1, 10, 7, 10);
      check($sformatf("s1_can_tx_b%0d", b), can_tx, pat[b]);
    end

    // Hard sync on the tick that would otherwise be the bit boundary
    bt_if.hard_sync_en = 1'b1;
    ticks("s2", 1, 9, 7, 0);
    rx = 1'b0;
    bt_if.tx_bit = 1'b0;
    tick("s2_hs", 10, 1'b0, 1'b0, 1'b1);
    bt_if.hard_sync_en = 1'b0;
    check("s2_no_tx_load", can_tx, 1'b1);
    ticks("s2_after", 1, 9, 6, 9);
    check("s2_sampled", bt_if.sampled_bit, 1'b0);
    check("s2_can_tx", can_tx, 1'b0);
    rx = 1'b1;
    bt_if.tx_bit = 1'b1;
    ticks("s2_norm", 1, 10, 7, 10);
    check("s2_norm_sampled", bt_if.sampled_bit, 1'b1);

    // Late edge at TSEG1 cnt=2 with SJ=2: TSEG1 stretches to 8 tq
    bt_if.sjw = 2'd1;
    ticks("s3", 1, 3, 0, 0);
    rx = 1'b0;
    tick("s3_edge", 4, 1'b0, 1'b0, 1'b0);
    tick("s3", 5, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    ticks("s3", 6, 12, 9, 12);
    check("s3_sampled", bt_if.sampled_bit, 1'b1);
    ticks("s3_next", 1, 10, 7, 10);

    // Early edge at TSEG2 cnt=0 (r=2): TSEG2 shortened to 2 tq
    bt_if.sjw = 2'd0;
    ticks("s4a", 1, 7, 7, 0);
    rx = 1'b0;
    tick("s4a_edge", 8, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    tick("s4a", 9, 1'b0, 1'b1, 1'b0);
    // Early edge at TSEG2 cnt=2 (r=0): bit ends on the edge tick, next tick is TSEG1
    bt_if.tx_bit = 1'b0;
    ticks("s4b", 1, 9, 7, 0);
    rx = 1'b0;
    tick("s4b_edge", 10, 1'b0, 1'b1, 1'b0);
    check("s4b_can_tx", can_tx, 1'b0);
    rx = 1'b1;
    ticks("s4c", 1, 9, 6, 9);
    check("s4c_sampled", bt_if.sampled_bit, 1'b1);

    // Second edge before the next sample point is ignored
    bt_if.tx_bit = 1'b1;
    ticks("s5a", 1, 7, 7, 0);
    rx = 1'b0;
    tick("s5a_edge", 8, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    tick("s5a", 9, 1'b0, 1'b1, 1'b0);
    tick("s5a_n", 1, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    tick("s5a_n_edge", 2, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    ticks("s5a_n", 3, 10, 7, 10);
    check("s5a_sampled", bt_if.sampled_bit, 1'b1);

    // Edge in SYNC leaves timing unchanged; edge while sampled_bit=0 is ignored
    rx = 1'b0;
    tick("s5b_sync_edge", 1, 1'b0, 1'b0, 1'b0);
    ticks("s5b", 2, 7, 7, 0);
    check("s5b_sampled", bt_if.sampled_bit, 1'b0);
    rx = 1'b1;
    ticks("s5b", 8, 9, 0, 0);
    rx = 1'b0;
    tick("s5b_edge", 10, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    ticks("s5b_after", 1, 10, 7, 10);
    check("s5b_after_sampled", bt_if.sampled_bit, 1'b1);

    // Asynchronous reset mid-TSEG1 forces recessive drive at once
    bt_if.tx_bit = 1'b0;
    ticks("s6_pre", 1, 10, 7, 10);
    check("s6_pre_can_tx", can_tx, 1'b0);
    ticks("s6_mid", 1, 4, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_can_tx", can_tx, 1'b1);
    check("s6_rst_pulses", bt_if.sample_point | bt_if.tx_point | bt_if.hard_synced, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bt_if.tx_bit = 1'b1;
    ticks("s6_rst", 1, 10, 7, 10);
    check("s6_rst_tx", can_tx, 1'b1);

    // ps2 2->5 mid-TSEG2: current TSEG2 stays 3 tq, next bit gets 6 tq
    ticks("s6_cfg", 1, 8, 7, 0);
    bt_if.phase_seg2 = 3'd5;
    ticks("s6_cfg", 9, 10, 0, 10);
    ticks("s6_ps2", 1, 13, 7, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
